// File: rtl/key_event.sv
// key_event: turns a debounced key level into short, double, long and repeat event pulses
module key_event #(
  parameter logic PRESS_LEVEL = 1'b1,
  parameter int   LONG_TIME   = 24000000,
  parameter int   DOUBLE_GAP  = 7200000,
  parameter int   REPEAT_TIME = 4800000,
  parameter int   DOUBLE_EN   = 1,
  parameter int   CNT_BITS    = 25
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_i,
  output logic short_o,
  output logic double_o,
  output logic long_o,
  output logic repeat_o,
  output logic held_o
);
  typedef enum logic [2:0] {IDLE, PRESS, LONG, GAP, PRESS2} state_t;
  localparam logic [CNT_BITS-1:0] LONG_END   = CNT_BITS'(LONG_TIME - 1);
  localparam logic [CNT_BITS-1:0] GAP_END    = CNT_BITS'(DOUBLE_GAP - 1);
  localparam logic [CNT_BITS-1:0] REPEAT_END = CNT_BITS'(REPEAT_TIME - 1);
  state_t state, state_nxt;
  logic [CNT_BITS-1:0] cnt, cnt_nxt;
  logic key_r, key_d, pressed, press_edge, release_edge;
  logic short_nxt, double_nxt, long_nxt, repeat_nxt;
  assign pressed      = key_r == PRESS_LEVEL;
  assign press_edge   = pressed && key_d != PRESS_LEVEL;
  assign release_edge = !pressed && key_d == PRESS_LEVEL;
  assign held_o       = pressed;
  always_comb begin
    state_nxt  = state;
    short_nxt  = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    case (state)
      IDLE: if (press_edge) state_nxt = PRESS;
      PRESS:
        if (release_edge) begin
          state_nxt = DOUBLE_EN != 0 ? GAP : IDLE;
          short_nxt = DOUBLE_EN == 0;
        end else if (pressed && cnt == LONG_END) begin
          long_nxt  = 1'b1;
          state_nxt = LONG;
        end
      LONG:
        if (release_edge) state_nxt = IDLE;
        else if (pressed && cnt == REPEAT_END) repeat_nxt = 1'b1;
      GAP:
        if (press_edge) state_nxt = PRESS2;
        else if (cnt == GAP_END) begin
          short_nxt = 1'b1;
          state_nxt = IDLE;
        end
      PRESS2:
        if (release_edge) begin
          double_nxt = 1'b1;
          state_nxt  = IDLE;
        end else if (pressed && cnt == LONG_END) begin
          long_nxt  = 1'b1;
          state_nxt = LONG;
        end
      default: state_nxt = IDLE;
    endcase
    cnt_nxt = (state_nxt != state || state == IDLE || repeat_nxt) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_r    <= key_i;
      key_d    <= key_i;
      state    <= IDLE;
      cnt      <= '0;
      short_o  <= 1'b0;
      double_o <= 1'b0;
      long_o   <= 1'b0;
      repeat_o <= 1'b0;
    end else begin
      key_r    <= key_i;
      key_d    <= key_r;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      short_o  <= short_nxt;
      double_o <= double_nxt;
      long_o   <= long_nxt;
      repeat_o <= repeat_nxt;
    end
  end
endmodule

// File: tb/tb_key_event.sv
// tb_key_event: random clicks on two instances (double-click on/off) checked against a timeline model
module tb_key_event;
  localparam int L = 20;
  localparam int G = 10;
  localparam int R = 5;
  localparam logic [3:0] EV_SHORT = 4'b1000;
  localparam logic [3:0] EV_DOUBLE = 4'b0100;
  localparam logic [3:0] EV_LONG = 4'b0010;
  localparam logic [3:0] EV_REPEAT = 4'b0001;
  typedef struct {int t; logic [3:0] k;} ev_t;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_i = 1'b0;
  logic [3:0] ev1, ev0;
  logic held1, held0, key_s;
  int cyc = 0;
  int asserts = 0;
  int failures = 0;
  bit pend = 0;
  ev_t q1[$];
  ev_t q0[$];
  key_event #(.PRESS_LEVEL(1'b1), .LONG_TIME(L), .DOUBLE_GAP(G), .REPEAT_TIME(R), .DOUBLE_EN(1), .CNT_BITS(5)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_i(key_i), .short_o(ev1[3]), .double_o(ev1[2]),
    .long_o(ev1[1]), .repeat_o(ev1[0]), .held_o(held1));
  key_event #(.PRESS_LEVEL(1'b1), .LONG_TIME(L), .DOUBLE_GAP(G), .REPEAT_TIME(R), .DOUBLE_EN(0), .CNT_BITS(5)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_i(key_i), .short_o(ev0[3]), .double_o(ev0[2]),
    .long_o(ev0[1]), .repeat_o(ev0[0]), .held_o(held0));
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(posedge sys_clk) key_s <= key_i;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic push(input int t, input logic [3:0] k, input bit to1, input bit to0);
    ev_t e;
    e.t = t;
    e.k = k;
    if (to1) q1.push_back(e);
    if (to0) q0.push_back(e);
  endtask
  task automatic observe(input bit en, input logic [3:0] ev);
    ev_t e;
    if ((en ? q1.size() : q0.size()) == 0) check(en ? "unexpected_en1" : "unexpected_en0", ev, 0);
    else begin
      if (en) e = q1.pop_front();
      else e = q0.pop_front();
      check(en ? "kind_en1" : "kind_en0", ev, e.k);
      check(en ? "time_en1" : "time_en0", cyc, e.t);
    end
  endtask
  always @(negedge sys_clk) if (cyc > 0) begin
    check("held_en1", held1, key_s);
    check("held_en0", held0, key_s);
    if (ev1 != 0) observe(1'b1, ev1);
    if (ev0 != 0) observe(1'b0, ev0);
  end
  // A click: key pressed for p samples, then released for d samples; expected pulses are
  // derived from durations alone. The first key_i sample s gives the PRESS entry at edge s+1.
  task automatic press(input int p, input int d);
    int s;
    @(negedge sys_clk);
    key_i = 1'b1;
    s = cyc + 1;
    if (p > L) begin
      for (int j = 0; p > L + R * j; j++) push(s + 1 + L + R * j, j == 0 ? EV_LONG : EV_REPEAT, 1'b1, 1'b1);
      pend = 0;
    end else begin
      push(s + p + 1, EV_SHORT, 1'b0, 1'b1);
      if (pend) begin
        push(s + p + 1, EV_DOUBLE, 1'b1, 1'b0);
        pend = 0;
      end else if (d > G) push(s + p + 1 + G, EV_SHORT, 1'b1, 1'b0);
      else pend = 1;
    end
    repeat (p - 1) @(negedge sys_clk);
    @(negedge sys_clk);
    key_i = 1'b0;
    repeat (d - 1) @(negedge sys_clk);
  endtask
  task automatic reset_in_long();
    int s;
    @(negedge sys_clk);
    key_i = 1'b1;
    s = cyc + 1;
    push(s + 1 + L, EV_LONG, 1'b1, 1'b1);
    push(s + 1 + L + R, EV_REPEAT, 1'b1, 1'b1);
    pend = 0;
    repeat (L + R + 2) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rst_long_pulses", {ev1, ev0}, 0);
    sys_rst = 1'b0;
    repeat (L + 10) @(negedge sys_clk);
    check("rst_long_held", {held1, held0}, 2'b11);
    key_i = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask
  initial begin
    int p, d;
    repeat (3) @(negedge sys_clk);
    check("reset_pulses", {ev1, ev0}, 0);
    check("reset_held", {held1, held0}, 2'b00);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    press(5, 15);
    press(5, 4);
    press(5, 15);
    press(37, 3);
    press(5, G);
    press(5, 15);
    press(3, G + 1);
    press(L, 12);
    press(L + 1, 3);
    reset_in_long();
    for (int i = 0; i < 50; i++) begin
      p = $urandom_range(0, 3) == 0 ? $urandom_range(L + 1, L + 12) : $urandom_range(1, L);
      d = i == 49 ? G + 5 : $urandom_range(1, G + 4);
      press(p, d);
    end
    repeat (40) @(negedge sys_clk);
    check("missing_en1", q1.size(), 0);
    check("missing_en0", q0.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Sits directly downstream of the key debouncer. Consumes its debounced key level and turns it into one-cycle event pulses: short press, double click, long press and auto-repeat while held.
- Outputs feed the control FSM and menu logic, which act on events rather than levels.
- One instance per key.

Parameters:
- PRESS_LEVEL, 1, key_i level that means "pressed".
- LONG_TIME, 24000000, cycles a press must be held to count as long (1 s at 24 MHz).
- DOUBLE_GAP, 7200000, maximum cycles between a release and the next press for a double click (300 ms).
- REPEAT_TIME, 4800000, cycles between repeat pulses once long is reached (200 ms).
- DOUBLE_EN, 1, 1 enables double-click detection; 0 reports a short press at release.
- CNT_BITS, 25, counter width. Must hold max(LONG_TIME, DOUBLE_GAP, REPEAT_TIME) - 1.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- key_i  input  1  debounced key level from the debouncer.
- short_o  output  1  one-cycle pulse: single short press.
- double_o  output  1  one-cycle pulse: double click.
- long_o  output  1  one-cycle pulse: press held LONG_TIME.
- repeat_o  output  1  one-cycle pulse every REPEAT_TIME while held after long.
- held_o  output  1  level: registered key is in the pressed state.

Behaviour:
- Input stage:
  - key_r <= key_i and key_d <= key_r every cycle.
  - pressed = (key_r == PRESS_LEVEL).
  - press_edge = pressed and key_d != PRESS_LEVEL.
  - release_edge = not pressed and key_d == PRESS_LEVEL.
  - held_o = pressed.
- Reset (sys_rst high at an edge):
  - state = IDLE, cnt = 0, all pulse outputs 0.
  - key_r and key_d both load key_i, so a key held through reset produces no press_edge.
  - Reset mid-operation discards the pending event; no pulse is emitted.
- Counter: a single cnt is cleared on every state change and increments by 1 per cycle otherwise. It never wraps, because every state leaves or clears before its limit.
- FSM transitions, evaluated each cycle from the registered state:
  - IDLE: press_edge -> PRESS, cnt = 0. Everything else is ignored.
  - PRESS:
    - release_edge -> GAP if DOUBLE_EN=1; otherwise short_o = 1 and -> IDLE.
    - cnt == LONG_TIME-1 while pressed -> long_o = 1, -> LONG.
  - LONG:
    - cnt == REPEAT_TIME-1 while pressed -> repeat_o = 1, cnt = 0, stay in LONG.
    - release_edge -> IDLE, with no short or double pulse.
    - If release and the repeat terminal count coincide, release wins and no repeat pulse is emitted.
  - GAP:
    - press_edge with cnt <= DOUBLE_GAP-1 -> PRESS2.
    - cnt == DOUBLE_GAP-1 with no press_edge -> short_o = 1, -> IDLE.
    - If press_edge and the terminal count coincide, press wins (-> PRESS2) and no short pulse is emitted.
  - PRESS2:
    - release_edge -> double_o = 1, -> IDLE.
    - cnt == LONG_TIME-1 while pressed -> long_o = 1, -> LONG. The first click is discarded and no short pulse is emitted.
- Outputs are registered. Each pulse is high for exactly one cycle, in the cycle after the edge that evaluates its trigger. At most one of short_o, double_o, long_o, repeat_o is high in any cycle.
- Latency:
  - A key_i change sampled at edge E gives key_r at E and press_edge/release_edge during cycle E..E+1.
  - The resulting state change and pulse register at E+1.
  - Long press: long_o rises LONG_TIME cycles after the PRESS entry edge.

Test Plan (LONG_TIME=20, DOUBLE_GAP=10, REPEAT_TIME=5, DOUBLE_EN=1, PRESS_LEVEL=1):
- Hold key_i=1 for 5 cycles, then 0 and idle 15 cycles -> exactly one short_o pulse, 10 cycles after the GAP entry edge. No other pulses.
- Press 5 cycles, release 4 cycles, press 5 cycles, release -> one double_o pulse, the cycle after the second release is registered. short_o never asserts.
- Hold key_i=1 for 37 cycles -> long_o at cycle 20 after PRESS entry, then repeat_o at +5, +10, +15. Release -> no short_o or double_o.
- Press 5 cycles, release, then press at GAP cnt=9 (coinciding with the terminal count) -> no short_o, state PRESS2, and a double_o pulse on the following release.
- Assert sys_rst for 1 cycle while in LONG with key held, then keep holding -> no pulses, state IDLE, held_o=1, no long_o until a fresh release and press.
- DOUBLE_EN=0: press 5 cycles and release -> short_o the cycle after release is registered. A second quick click produces a second short_o, never double_o.
